nibble_capture_fifo: RTL
========================

NIBBLE_CAPTURE_FIFO -- requirements
Module: nibble_capture_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of stored entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port flush, input, 1 bit: synchronous clear of the FIFO contents.
REQ-006 Port in_data, input, WIDTH bits: word from the upstream 4-bit inverter output y.
REQ-007 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-008 Port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 Port out_data, output, WIDTH bits: head-of-queue word.
REQ-010 Port out_valid, output, 1 bit: out_data is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer takes out_data this cycle.
REQ-012 Port count, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-013 Port overflow, output, 1 bit: sticky flag for a word offered while the FIFO was full.
REQ-014 Port clear_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-015 A push SHALL occur on a clock edge where in_valid=1, in_ready=1 and flush=0.
REQ-016 A pop SHALL occur on a clock edge where out_valid=1, out_ready=1 and flush=0.
REQ-017 in_ready SHALL equal (state != FULL); it SHALL have no combinational dependence on out_ready, so a push is refused while full even if a pop happens in the same cycle.
REQ-018 out_valid SHALL equal (state != EMPTY), and out_data SHALL equal the oldest stored word (first-word fall-through).
REQ-019 A word pushed at edge N SHALL appear on out_data with out_valid=1 after edge N when the FIFO was empty (latency 1 cycle).
REQ-020 Words SHALL exit in push order, unmodified.
REQ-021 FSM states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
REQ-022 EMPTY->PARTIAL on push; PARTIAL->FULL on push without pop when count=DEPTH-1; PARTIAL->EMPTY on pop without push when count=1; FULL->PARTIAL on pop; any state->EMPTY on flush; all other cases hold state.
REQ-023 A simultaneous push and pop in PARTIAL SHALL leave count unchanged and advance both pointers.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-025 overflow SHALL be set at an edge where in_valid=1 and state=FULL, and SHALL hold until an edge with clear_ovf=1.
REQ-026 If clear_ovf and a new overflow condition occur on the same edge, overflow SHALL end up 1 (set wins).
REQ-027 flush SHALL reset the pointers and count and move the FSM to EMPTY. It SHALL take priority over push and pop, SHALL leave overflow unchanged, and SHALL NOT require the storage array to be cleared.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=EMPTY, pointers=0, count=0, overflow=0, so in_ready=1 and out_valid=0.
REQ-029 out_data is don't-care while out_valid=0, including during and after reset.
REQ-030 A reset asserted mid-operation SHALL discard all stored words; the first push after release SHALL be the first word popped.
REQ-031 The storage array SHALL NOT be reset.

Structure
REQ-032 Package nibble_pkg SHALL hold the default WIDTH and DEPTH constants and the FSM state typedef (EMPTY, PARTIAL, FULL).
REQ-033 Storage SHALL be one sub-module, nibble_fifo_mem, with one write port and one combinational read port.
REQ-034 The FSM, pointers, count and overflow logic SHALL reside in nibble_capture_fifo.

Verification
REQ-035 Reset, then push 1, 0, 1, 0 (inverter output E, F, E, F) with out_ready=0 -> count=4, out_data=4'hE, in_ready=1.
REQ-036 Push 8 words 0..7, then offer 4'h9 -> in_ready=0, overflow=1, 4'h9 is never popped; pop all -> outputs 0..7 in order, then EMPTY.
REQ-037 Hold in_valid=1 and out_ready=1 with a streaming counter for 20 cycles -> count stays 1, output sequence equals input sequence delayed by 1 cycle, and the pointers wrap with no loss.
REQ-038 FIFO full with overflow=1; apply flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, overflow still 1; then clear_ovf -> overflow=0.
REQ-039 With 3 words stored, assert rst_n=0 between clock edges -> count=0 and out_valid=0 immediately, without waiting for a clock; after release, push 4'hA -> the next pop returns 4'hA.
REQ-040 FULL state, in_valid=1 and clear_ovf=1 on the same edge -> overflow=1.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared constants and FSM state type for the nibble capture FIFO.
// The FIFO buffers words coming from the upstream 4-bit inverter output.
package nibble_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/nibble_fifo_mem.sv
// FIFO storage: one synchronous write port, one combinational read port.
// The contents are meaningless until written; the controller never exposes unwritten entries.
module nibble_fifo_mem
    import nibble_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the controller, so the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nibble_capture_fifo.sv
// First-word fall-through FIFO with EMPTY/PARTIAL/FULL control FSM, flush and
// a sticky overflow flag for words offered while full.
module nibble_capture_fifo
    import nibble_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             overflow,
    input  logic             clear_ovf
);

    fifo_state_t   state;
    fifo_state_t   state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Ready depends only on state, never on out_ready, so a full FIFO refuses
    // a push even when a pop happens on the same edge.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // NOTE: state_nxt gets a default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = PARTIAL;
            PARTIAL: begin
                if (push && !pop && count == CW'(DEPTH - 1)) begin
                    state_nxt = FULL;
                end else if (pop && !push && count == CW'(1)) begin
                    state_nxt = EMPTY;
                end
            end
            FULL:    if (pop) state_nxt = PARTIAL;
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                // Pointers are exactly AW bits, so DEPTH-1 + 1 wraps to 0.
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Overflow is independent of flush; a fresh overflow beats clear_ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid && state == FULL) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    nibble_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

endmodule
